led_status_arbiter: RTL and testbench
=====================================

# led_status_arbiter

Shares the single board status LED between a free-running heartbeat and up to `NUM_REQ` status requesters (S/PDIF lock lost, parity error, FIFO overrun, etc.). When any requester is active, the block grants the LED to the highest-priority one. It then plays that requester's blink code, which is a fixed number of pulses followed by a gap, before arbitrating again. When no request is pending, the heartbeat pattern passes through to the LED. The block sits between the status sources of the S/PDIF receiver and the top-level `led_o` pin.

## Interface
- `NUM_REQ`, 4: number of requesters, 1..8; requester `i` blinks `i+1` times.
- `TICK_DIV`, 16000: clocks per tick (1 ms at 16 MHz).
- `ON_TICKS`, 150: LED-on ticks per blink, ≥1.
- `OFF_TICKS`, 250: LED-off ticks after each blink, ≥1.
- `GAP_TICKS`, 1000: LED-off ticks after the last blink's OFF, ≥1.

- `clock_i`  in  1  global clock.
- `resetn_i`  in  1  asynchronous, active-low reset.
- `req_i`  in  NUM_REQ  level requests, synchronous to `clock_i`; bit 0 has highest priority.
- `heartbeat_i`  in  1  heartbeat pulse, shown when idle.
- `led_o`  out  1  registered LED drive.
- `grant_o`  out  NUM_REQ  registered one-hot grant; all-zero when idle.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, ON, OFF, GAP.
- **Reset (async, resetn_i=0):**
  - state=IDLE, `led_o`=0, `grant_o`=0, `busy_o`=0.
  - Prescaler, tick counter and blink counter are cleared.
  - Reset asserted mid-code aborts the code immediately.
- **IDLE:**
  - `led_o` <= `heartbeat_i` every clock.
  - If `req_i`≠0, the lowest set index `k` wins. On that edge:
    - `grant_o` <= one-hot(k), blinks_left <= k+1, go to ON.
    - Prescaler and tick counter are cleared.
    - `led_o` <= 1 on the same edge.
- **ON:**
  - `led_o`=1 for exactly ON_TICKS×TICK_DIV clocks, then go to OFF with `led_o` <= 0.
  - blinks_left decrements on the ON→OFF edge.
- **OFF:**
  - `led_o`=0 for exactly OFF_TICKS×TICK_DIV clocks.
  - If blinks_left≠0, go to ON with `led_o` <= 1; otherwise go to GAP.
- **GAP:**
  - `led_o`=0 for GAP_TICKS×TICK_DIV clocks, then go to IDLE.
  - `grant_o` <= 0 on the GAP→IDLE edge.
- **Non-preemptive:**
  - Deasserting the granted request, or asserting a higher-priority one, never shortens the current code.
  - The new winner is chosen only in IDLE.
- **Re-arbitration:**
  - On the first IDLE clock, a still-pending request is granted again on the next edge.
  - IDLE therefore lasts exactly 1 clock between back-to-back codes.
  - `led_o` shows `heartbeat_i` during that clock.
- **Counters:**
  - The prescaler is `$clog2(TICK_DIV)` bits and wraps at TICK_DIV-1, producing a 1-clock tick.
  - The tick counter is wide enough for max(ON,OFF,GAP)_TICKS and clears on every state transition.
  - blinks_left is `$clog2(NUM_REQ+1)` bits.
  - No counter may wrap inside a state.

## Timing
- **Latency:**
  - Request to `led_o`=1: the `req_i` edge in IDLE is sampled on the next clock edge, and `led_o`/`grant_o`/`busy_o` change on that same edge (1 clock).
  - `heartbeat_i` to `led_o`: 1 clock.
- **Code length** for requester k: (k+1)×(ON_TICKS+OFF_TICKS)×TICK_DIV + GAP_TICKS×TICK_DIV clocks from the grant edge to the IDLE edge.
- **`busy_o`** equals (state≠IDLE) and is registered with the state.
- **Simultaneous requests:** the lowest index wins, and the others wait. Lower-priority requests can starve while a higher one stays asserted; this is accepted.
- `req_i` is sampled only in IDLE; its glitches in other states are ignored.

## Test plan
Bench parameters: TICK_DIV=4, ON_TICKS=2, OFF_TICKS=3, GAP_TICKS=5, giving ON=8, OFF=12 and GAP=20 clocks.

1. **Reset values:** hold `resetn_i`=0 with `req_i`=4'b1111 and `heartbeat_i`=1 → `led_o`=0, `grant_o`=0, `busy_o`=0; release → `led_o` follows `heartbeat_i` one clock later only while `req_i`=0.
2. **Single code:** pulse `req_i`[2] for 1 clock in IDLE → `grant_o`=4'b0100 and exactly 3 high runs of 8 clocks on `led_o`, separated by 12-clock lows, then a 20-clock low; `busy_o` stays high for exactly 80 clocks.
3. **Priority:** assert `req_i`=4'b1010 on the same clock → `grant_o`=4'b0010 and 2 blinks. With `req_i`[3] still high, IDLE lasts 1 clock, then `grant_o`=4'b1000 and 4 blinks (100 clocks busy).
4. **Non-preemption:** during requester 3's second ON, assert `req_i`[0] and drop `req_i`[3] → the 4-blink code completes unchanged (100 clocks), then `grant_o`=4'b0001 and 1 blink (40 clocks).
5. **Async reset mid-code:** drop `resetn_i` asynchronously (between edges) during OFF of a requester-1 code → outputs go to 0 without waiting for an edge. After release with `req_i`[1] still high, a full fresh 2-blink code plays from the start.
6. **Idle passthrough:** with `req_i`=0, toggle `heartbeat_i` in an arbitrary pattern → `led_o` equals `heartbeat_i` delayed by exactly 1 clock, and `grant_o` stays 0.

Source files
------------

// File: rtl/led_status_arbiter.sv
// Status LED arbiter: shares one LED between a heartbeat and NUM_REQ
// requesters. The highest-priority requester (lowest index) is granted
// the LED and plays i+1 blinks followed by a gap. After that the block
// returns to IDLE and arbitrates again. When no request is pending, the
// heartbeat is passed through to the LED.
module led_status_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TICK_DIV  = 16000,
    parameter int ON_TICKS  = 150,
    parameter int OFF_TICKS = 250,
    parameter int GAP_TICKS = 1000
) (
    input  logic               clock_i,
    input  logic               resetn_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               heartbeat_i,
    output logic               led_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               busy_o
);

    localparam int MAX_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_TICKS  = (MAX_ON_OFF > GAP_TICKS) ? MAX_ON_OFF : GAP_TICKS;
    localparam int PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TICK_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int BLINK_W    = $clog2(NUM_REQ + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_GAP
    } state_t;

    state_t               state, state_next;
    logic [PRESC_W-1:0]   presc, presc_next;
    logic [TICK_W-1:0]    ticks, ticks_next;
    logic [BLINK_W-1:0]   blinks, blinks_next;
    logic                 led_next;
    logic                 tick;
    logic [NUM_REQ-1:0]   grant_next;
    logic [NUM_REQ-1:0]   win_grant;
    logic [BLINK_W-1:0]   win_blinks;

    // Fixed-priority pick: scanning downward lets the lowest set index win.
    always_comb begin
        win_grant  = '0;
        win_blinks = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                win_grant    = '0;
                win_grant[i] = 1'b1;
                win_blinks   = BLINK_W'(i + 1);
            end
        end
    end

    // Next-state, counter and LED decode for the blink-code sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_next  = state;
        led_next    = led_o;
        grant_next  = grant_o;
        blinks_next = blinks;
        tick        = (presc == PRESC_W'(TICK_DIV - 1));
        presc_next  = tick ? '0 : presc + 1'b1;
        ticks_next  = tick ? ticks + 1'b1 : ticks;

        case (state)
            ST_IDLE: begin
                led_next   = heartbeat_i;
                presc_next = '0;
                ticks_next = '0;
                if (|req_i) begin
                    state_next  = ST_ON;
                    grant_next  = win_grant;
                    blinks_next = win_blinks;
                    led_next    = 1'b1;
                end
            end
            ST_ON: begin
                if (tick && ticks == TICK_W'(ON_TICKS - 1)) begin
                    state_next  = ST_OFF;
                    led_next    = 1'b0;
                    blinks_next = blinks - 1'b1;
                    presc_next  = '0;
                    ticks_next  = '0;
                end
            end
            ST_OFF: begin
                if (tick && ticks == TICK_W'(OFF_TICKS - 1)) begin
                    presc_next = '0;
                    ticks_next = '0;
                    if (blinks != '0) begin
                        state_next = ST_ON;
                        led_next   = 1'b1;
                    end else begin
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (tick && ticks == TICK_W'(GAP_TICKS - 1)) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                    presc_next = '0;
                    ticks_next = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs; reset aborts any code at once.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state   <= ST_IDLE;
            presc   <= '0;
            ticks   <= '0;
            blinks  <= '0;
            led_o   <= 1'b0;
            grant_o <= '0;
            busy_o  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state   <= state_next;
            presc   <= presc_next;
            ticks   <= ticks_next;
            blinks  <= blinks_next;
            led_o   <= led_next;
            grant_o <= grant_next;
            busy_o  <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_led_status_arbiter.sv
// Self-checking bench for led_status_arbiter. A position-in-code reference
// model runs continuously, while directed sequences check the run lengths,
// priority, non-preemption, async reset and heartbeat passthrough.
module tb_led_status_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int TICK_DIV  = 4;
    localparam int ON_TICKS  = 2;
    localparam int OFF_TICKS = 3;
    localparam int GAP_TICKS = 5;
    localparam int ON_CLK    = ON_TICKS * TICK_DIV;
    localparam int OFF_CLK   = OFF_TICKS * TICK_DIV;
    localparam int GAP_CLK   = GAP_TICKS * TICK_DIV;
    localparam int PERIOD    = ON_CLK + OFF_CLK;

    logic               clock_i = 1'b0;
    logic               resetn_i = 1'b0;
    logic [NUM_REQ-1:0] req_i = '0;
    logic               heartbeat_i = 1'b0;
    logic               led_o;
    logic [NUM_REQ-1:0] grant_o;
    logic               busy_o;

    led_status_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .TICK_DIV (TICK_DIV),
        .ON_TICKS (ON_TICKS),
        .OFF_TICKS(OFF_TICKS),
        .GAP_TICKS(GAP_TICKS)
    ) dut (
        .clock_i    (clock_i),
        .resetn_i   (resetn_i),
        .req_i      (req_i),
        .heartbeat_i(heartbeat_i),
        .led_o      (led_o),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
    );

    always #5 clock_i = ~clock_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a code is a position counter within a waveform
    // defined by arithmetic on the blink period.
    int               m_pos = -1;
    int               m_k   = 0;
    logic             m_led = 1'b0;
    logic [NUM_REQ-1:0] m_grant = '0;
    logic             m_busy = 1'b0;

    function automatic int lowest_set(input logic [NUM_REQ-1:0] r);
        for (int i = 0; i < NUM_REQ; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic int code_len(input int k);
        return (k + 1) * PERIOD + GAP_CLK;
    endfunction

    function automatic logic led_at(input int k, input int p);
        return (p < (k + 1) * PERIOD) && ((p % PERIOD) < ON_CLK);
    endfunction

    always @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            m_pos   <= -1;
            m_led   <= 1'b0;
            m_grant <= '0;
            m_busy  <= 1'b0;
        end else if (m_pos < 0) begin
            if (req_i != '0) begin
                m_k     <= lowest_set(req_i);
                m_pos   <= 0;
                m_led   <= 1'b1;
                m_grant <= NUM_REQ'(1) << lowest_set(req_i);
                m_busy  <= 1'b1;
            end else begin
                m_led   <= heartbeat_i;
                m_grant <= '0;
                m_busy  <= 1'b0;
            end
        end else if (m_pos + 1 == code_len(m_k)) begin
            m_pos   <= -1;
            m_led   <= 1'b0;
            m_grant <= '0;
            m_busy  <= 1'b0;
        end else begin
            m_pos <= m_pos + 1;
            m_led <= led_at(m_k, m_pos + 1);
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clock_i) begin
        if (chk_en) begin
            check("model_led", led_o, m_led);
            check("model_grant", grant_o, m_grant);
            check("model_busy", busy_o, m_busy);
        end
    end

    logic trace[$];
    int   runs[$];

    // Called at the grant negedge; records led until busy drops.
    task automatic finish_code(input int poke_at, input logic [NUM_REQ-1:0] poke_req, output int len);
        bit done;
        done = 1'b0;
        trace.delete();
        trace.push_back(led_o);
        len = 1;
        for (int n = 0; n < 400 && !done; n++) begin
            if (len == poke_at) req_i = poke_req;
            @(negedge clock_i);
            if (!busy_o) done = 1'b1;
            else begin
                trace.push_back(led_o);
                len++;
            end
        end
        if (!done) check("code_end_timeout", busy_o, 0);
    endtask

    task automatic check_runs(input int k, input string tag);
        int   run_len;
        logic cur;
        int   exp;
        runs.delete();
        cur = trace[0];
        run_len = 0;
        foreach (trace[i]) begin
            if (trace[i] == cur) run_len++;
            else begin
                runs.push_back(run_len);
                cur = trace[i];
                run_len = 1;
            end
        end
        if (trace.size() > 0) runs.push_back(run_len);
        check($sformatf("%s_first_led", tag), trace[0], 1);
        check($sformatf("%s_nruns", tag), runs.size(), 2 * (k + 1));
        for (int i = 0; i < runs.size() && i < 2 * (k + 1); i++) begin
            if (i % 2 == 0) exp = ON_CLK;
            else if (i == 2 * k + 1) exp = OFF_CLK + GAP_CLK;
            else exp = OFF_CLK;
            check($sformatf("%s_run%0d", tag, i), runs[i], exp);
        end
    endtask

    typedef struct {
        logic [NUM_REQ-1:0] req;
        logic               hb;
        logic               exp_led;
        logic [NUM_REQ-1:0] exp_grant;
        logic               exp_busy;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        int   len;
        vecs[0] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0};
        vecs[1] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
        vecs[2] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
        vecs[3] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0};
        vecs[4] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0};
        vecs[5] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
        vecs[6] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0};
        vecs[7] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
        vecs[8] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0};
        vecs[9] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1};

        // Reset values with all requests pending.
        resetn_i = 1'b0;
        req_i = 4'b1111;
        heartbeat_i = 1'b1;
        repeat (3) @(negedge clock_i);
        check("rst_led", led_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_busy", busy_o, 0);
        chk_en = 1'b1;
        req_i = '0;
        resetn_i = 1'b1;
        @(negedge clock_i);
        check("release_led", led_o, 1);
        heartbeat_i = 1'b0;
        @(negedge clock_i);
        check("release_led_follow", led_o, 0);

        // Heartbeat passthrough table, ending in a request.
        for (int i = 0; i < 10; i++) begin
            req_i = vecs[i].req;
            heartbeat_i = vecs[i].hb;
            @(negedge clock_i);
            check($sformatf("vec%0d_led", i), led_o, vecs[i].exp_led);
            check($sformatf("vec%0d_grant", i), grant_o, vecs[i].exp_grant);
            check($sformatf("vec%0d_busy", i), busy_o, vecs[i].exp_busy);
        end
        req_i = '0;
        finish_code(-1, '0, len);
        check("req0_busy_len", len, 40);
        check_runs(0, "req0");
        check("req0_idle_grant", grant_o, 0);

        // Single one-clock pulse on requester 2.
        req_i = 4'b0100;
        @(negedge clock_i);
        req_i = '0;
        check("single_grant", grant_o, 4'b0100);
        finish_code(-1, '0, len);
        check("single_busy_len", len, 80);
        check_runs(2, "single");

        // Priority: 1 beats 3; 3 follows after a one-clock IDLE.
        req_i = 4'b1010;
        @(negedge clock_i);
        check("prio_grant1", grant_o, 4'b0010);
        req_i = 4'b1000;
        finish_code(-1, '0, len);
        check("prio_busy_len1", len, 60);
        check_runs(1, "prio1");
        check("prio_idle_busy", busy_o, 0);
        check("prio_idle_grant", grant_o, 0);
        @(negedge clock_i);
        check("prio_grant3", grant_o, 4'b1000);
        check("prio_busy3", busy_o, 1);

        // Non-preemption: swap requests during the second ON of requester 3.
        finish_code(23, 4'b0001, len);
        check("nopre_busy_len", len, 100);
        check_runs(3, "nopre");
        check("nopre_idle_busy", busy_o, 0);
        @(negedge clock_i);
        check("nopre_grant0", grant_o, 4'b0001);
        req_i = '0;
        finish_code(-1, '0, len);
        check("nopre_busy_len0", len, 40);

        // Async reset in the OFF phase of a requester-1 code.
        req_i = 4'b0010;
        @(negedge clock_i);
        check("arst_grant", grant_o, 4'b0010);
        repeat (10) @(negedge clock_i);
        check("arst_in_off_led", led_o, 0);
        #2 resetn_i = 1'b0;
        #1;
        check("arst_led", led_o, 0);
        check("arst_grant0", grant_o, 0);
        check("arst_busy", busy_o, 0);
        @(negedge clock_i);
        resetn_i = 1'b1;
        @(negedge clock_i);
        check("arst_regrant", grant_o, 4'b0010);
        req_i = '0;
        finish_code(-1, '0, len);
        check("arst_busy_len", len, 60);
        check_runs(1, "arst");

        // Random requests, heartbeat and occasional async resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock_i);
            heartbeat_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) req_i = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 799) == 0) begin
                #2 resetn_i = 1'b0;
                #1 check("rand_arst_busy", busy_o, 0);
                @(negedge clock_i);
                resetn_i = 1'b1;
            end
        end

        @(negedge clock_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
